// File: rtl/reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_pkg
//  Description : Operation codes shared by the general-purpose register slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_INC  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_DEC  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_CLR  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b111;

endpackage
`default_nettype wire

// File: rtl/reg_n_bit_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_n_bit_if
//  Description : Control/data bundle between a datapath controller and a register.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_n_bit_if #(
    parameter int WIDTH = 6
) ();
    import reg_pkg::*;

    logic              sel;
    logic [MODE_W-1:0] mode;
    logic [WIDTH-1:0]  d_in;
    logic              ser_in;
    logic [WIDTH-1:0]  d_out;
    logic              carry;
    logic              zero;
    logic              ser_out;

    modport master (
        output sel, mode, d_in, ser_in,
        input  d_out, carry, zero, ser_out
    );

    modport slave (
        input  sel, mode, d_in, ser_in,
        output d_out, carry, zero, ser_out
    );

endinterface
`default_nettype wire

// File: rtl/reg_next_state.sv
`default_nettype none
// ============================================================================
//  Module      : reg_next_state
//  Description : Combinational next-value, next-carry and serial-out selection.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_next_state
    import reg_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  wire logic [MODE_W-1:0] mode,
    input  wire logic [WIDTH-1:0]  d_out,
    input  wire logic              carry,
    input  wire logic              ser_in,
    input  wire logic [WIDTH-1:0]  d_in,
    output logic      [WIDTH-1:0]  next_val,
    output logic                   next_carry,
    output logic                   ser_out
);

    always_comb begin
        next_val   = d_out;
        next_carry = carry;
        case (mode)
            MODE_HOLD: begin
                next_val   = d_out;
                next_carry = carry;
            end
            MODE_LOAD: begin
                next_val   = d_in;
                next_carry = 1'b0;
            end
            MODE_SHL: begin
                next_val   = {d_out[WIDTH-2:0], ser_in};
                next_carry = d_out[WIDTH-1];
            end
            MODE_SHR: begin
                next_val   = {ser_in, d_out[WIDTH-1:1]};
                next_carry = d_out[0];
            end
            // Carry/borrow flags the wrap rather than a widened sum bit.
            MODE_INC: begin
                next_val   = d_out + WIDTH'(1);
                next_carry = &d_out;
            end
            MODE_DEC: begin
                next_val   = d_out - WIDTH'(1);
                next_carry = ~|d_out;
            end
            MODE_CLR: begin
                next_val   = '0;
                next_carry = 1'b0;
            end
            MODE_ROL: begin
                next_val   = {d_out[WIDTH-2:0], d_out[WIDTH-1]};
                next_carry = d_out[WIDTH-1];
            end
            default: begin
                next_val   = d_out;
                next_carry = carry;
            end
        endcase
    end

    always_comb begin
        ser_out = 1'b0;
        if ((mode == MODE_SHL) || (mode == MODE_ROL)) begin
            ser_out = d_out[WIDTH-1];
        end else if (mode == MODE_SHR) begin
            ser_out = d_out[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_n_bit.sv
`default_nettype none
// ============================================================================
//  Module      : reg_n_bit
//  Description : WIDTH-bit register with load/shift/rotate/inc/dec/clear modes.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_n_bit
    import reg_pkg::*;
#(
    parameter int               WIDTH     = 6,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic   clk,
    input  wire logic   rst,
    reg_n_bit_if.slave  bus
);

    logic [WIDTH-1:0] r_d_out;
    logic             r_carry;
    logic [WIDTH-1:0] w_next_val;
    logic             w_next_carry;
    logic             w_ser_out;

    reg_next_state #(
        .WIDTH (WIDTH)
    ) u_next_state (
        .mode       (bus.mode),
        .d_out      (r_d_out),
        .carry      (r_carry),
        .ser_in     (bus.ser_in),
        .d_in       (bus.d_in),
        .next_val   (w_next_val),
        .next_carry (w_next_carry),
        .ser_out    (w_ser_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_out <= RESET_VAL;
            r_carry <= 1'b0;
        end else if (bus.sel) begin
            r_d_out <= w_next_val;
            r_carry <= w_next_carry;
        end
    end

    assign bus.d_out   = r_d_out;
    assign bus.carry   = r_carry;
    assign bus.zero    = ~|r_d_out;
    // Sampled before the edge so a chained neighbour sees the outgoing bit.
    assign bus.ser_out = w_ser_out;

endmodule
`default_nettype wire
